// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, sequencer state encoding and
// the ALU-operation classifier used by the sequencer and the datapath decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_DECODE = 3'd3,
    ST_OPER   = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WBACK  = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  // Opcodes that fetch an operand and push it through the ALU into the accumulator.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/machine_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: walks the fetch/decode/execute
// states and decodes the memory, IR, PC, ALU and accumulator strobes from the current state.
module machine_ctrl
  import cpu_pkg::*;
#(
  parameter int USE_RDY = 1,
  parameter int OP_W    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_rdy,
  output logic            rd,
  output logic            wr,
  output logic            load_ir,
  output logic            ir_lo,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            alu_en,
  output logic            load_acc,
  output logic            data_oe,
  output logic            halt
);

  if (OP_W != 3) begin : g_op_w_check
    $error("machine_ctrl: OP_W must be 3");
  end

  state_e     state_r;
  state_e     next_state_s;
  logic       skip_r;
  logic       rdy_s;
  logic [2:0] op_s;

  assign op_s  = opcode;
  assign rdy_s = (USE_RDY != 0) ? mem_rdy : 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // SKZ decision: zero is captured once in DECODE so later flag changes cannot alter the skip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_r <= 1'b0;
    end else if (state_r == ST_DECODE) begin
      skip_r <= (op_s == SKZ) && zero;
    end else begin
      skip_r <= skip_r;
    end
  end

  // Next-state logic; memory states stall until the bus reports ready.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ena) next_state_s = ST_FETCH1;
        else     next_state_s = ST_IDLE;
      end
      ST_FETCH1: begin
        if (rdy_s) next_state_s = ST_FETCH2;
        else       next_state_s = ST_FETCH1;
      end
      ST_FETCH2: begin
        if (rdy_s) next_state_s = ST_DECODE;
        else       next_state_s = ST_FETCH2;
      end
      ST_DECODE: begin
        if (op_s == HLT) next_state_s = ST_HALT;
        else             next_state_s = ST_OPER;
      end
      ST_OPER: begin
        if (is_alu_op(op_s) && !rdy_s) next_state_s = ST_OPER;
        else                           next_state_s = ST_EXEC;
      end
      ST_EXEC: begin
        next_state_s = ST_WBACK;
      end
      ST_WBACK: begin
        if ((op_s == STO) && !rdy_s) next_state_s = ST_WBACK;
        else if (ena)                next_state_s = ST_FETCH1;
        else                         next_state_s = ST_IDLE;
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Strobe decode; inc_pc in the fetch states fires only on the ready cycle.
  always_comb begin
    rd       = 1'b0;
    wr       = 1'b0;
    load_ir  = 1'b0;
    ir_lo    = 1'b0;
    inc_pc   = 1'b0;
    load_pc  = 1'b0;
    alu_en   = 1'b0;
    load_acc = 1'b0;
    data_oe  = 1'b0;
    halt     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        halt = 1'b0;
      end
      ST_FETCH1: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        ir_lo   = 1'b0;
        inc_pc  = rdy_s;
      end
      ST_FETCH2: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        ir_lo   = 1'b1;
        inc_pc  = rdy_s;
      end
      ST_DECODE: begin
        halt = 1'b0;
      end
      ST_OPER: begin
        case (op_s)
          ADD, AND, XOR, LDA: rd      = 1'b1;
          SKZ:                inc_pc  = skip_r;
          JMP:                load_pc = 1'b1;
          default:            rd      = 1'b0;
        endcase
      end
      ST_EXEC: begin
        case (op_s)
          ADD, AND, XOR, LDA: alu_en = 1'b1;
          SKZ:                inc_pc = skip_r;
          default:            alu_en = 1'b0;
        endcase
      end
      ST_WBACK: begin
        case (op_s)
          ADD, AND, XOR, LDA: load_acc = 1'b1;
          STO: begin
            wr      = 1'b1;
            data_oe = 1'b1;
          end
          default:            load_acc = 1'b0;
        endcase
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      default: begin
        halt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_ctrl.sv
// Self-checking bench for machine_ctrl: directed scenarios with literal traces plus
// randomized runs, both DUT flavours (USE_RDY=1 and USE_RDY=0) checked every cycle.
module tb_machine_ctrl;

  localparam int I_RD = 9, I_WR = 8, I_LIR = 7, I_IRLO = 6, I_INC = 5;
  localparam int I_LPC = 4, I_ALU = 3, I_LACC = 2, I_DOE = 1, I_HALT = 0;
  localparam logic [2:0] O_HLT = 3'd0, O_SKZ = 3'd1, O_ADD = 3'd2, O_LDA = 3'd5;
  localparam logic [2:0] O_STO = 3'd6, O_JMP = 3'd7;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b1;
  logic [2:0] opcode_a = 3'd0;
  logic [2:0] opcode_b = 3'd0;
  logic [9:0] out_a, out_b, cur_a, cur_b;

  int checks = 0;
  int passes = 0;
  int m_mode [2];
  int m_step [2];
  bit m_skip [2];

  always #5 clk = ~clk;

  machine_ctrl #(.USE_RDY(1), .OP_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode_a), .zero(zero), .mem_rdy(mem_rdy),
    .rd(out_a[I_RD]), .wr(out_a[I_WR]), .load_ir(out_a[I_LIR]), .ir_lo(out_a[I_IRLO]),
    .inc_pc(out_a[I_INC]), .load_pc(out_a[I_LPC]), .alu_en(out_a[I_ALU]),
    .load_acc(out_a[I_LACC]), .data_oe(out_a[I_DOE]), .halt(out_a[I_HALT])
  );

  machine_ctrl #(.USE_RDY(0), .OP_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode_b), .zero(zero), .mem_rdy(mem_rdy),
    .rd(out_b[I_RD]), .wr(out_b[I_WR]), .load_ir(out_b[I_LIR]), .ir_lo(out_b[I_IRLO]),
    .inc_pc(out_b[I_INC]), .load_pc(out_b[I_LPC]), .alu_en(out_b[I_ALU]),
    .load_acc(out_b[I_LACC]), .data_oe(out_b[I_DOE]), .halt(out_b[I_HALT])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit is_alu(input logic [2:0] op);
    return (op >= 3'd2) && (op <= 3'd5);
  endfunction

  // Steps of an instruction: 0 fetch hi, 1 fetch lo, 2 decode, 3 operand, 4 execute, 5 writeback.
  function automatic bit is_mem_step(input int s, input logic [2:0] op);
    return (s <= 1) || (s == 3 && is_alu(op)) || (s == 5 && op == O_STO);
  endfunction

  function automatic logic [9:0] model_out(input int d, input logic rdy, input logic [2:0] op);
    logic [9:0] o;
    o = 10'd0;
    if (m_mode[d] == M_HALT) o[I_HALT] = 1'b1;
    else if (m_mode[d] == M_RUN) begin
      if (m_step[d] <= 1) begin
        o[I_RD] = 1'b1; o[I_LIR] = 1'b1; o[I_INC] = rdy;
        o[I_IRLO] = (m_step[d] == 1);
      end else if (m_step[d] == 3) begin
        o[I_RD] = is_alu(op); o[I_LPC] = (op == O_JMP);
        o[I_INC] = (op == O_SKZ) && m_skip[d];
      end else if (m_step[d] == 4) begin
        o[I_ALU] = is_alu(op); o[I_INC] = (op == O_SKZ) && m_skip[d];
      end else if (m_step[d] == 5) begin
        o[I_LACC] = is_alu(op); o[I_WR] = (op == O_STO); o[I_DOE] = (op == O_STO);
      end
    end
    return o;
  endfunction

  task automatic model_step(input int d, input logic rdy, input logic e, input logic z,
                            input logic [2:0] op);
    if (m_mode[d] == M_IDLE) begin
      if (e) begin m_mode[d] = M_RUN; m_step[d] = 0; end
    end else if (m_mode[d] == M_RUN) begin
      if (is_mem_step(m_step[d], op) && !rdy) begin
        m_step[d] = m_step[d];
      end else if (m_step[d] == 2) begin
        m_skip[d] = (op == O_SKZ) && z;
        if (op == O_HLT) m_mode[d] = M_HALT;
        else m_step[d] = 3;
      end else if (m_step[d] == 5) begin
        if (e) m_step[d] = 0;
        else m_mode[d] = M_IDLE;
      end else begin
        m_step[d] = m_step[d] + 1;
      end
    end
  endtask

  // One clock: drive at the falling edge, compare both DUTs, advance the model.
  task automatic tick(input logic r_n, input logic e, input logic mr, input logic z,
                      input logic [2:0] opa, input logic [2:0] opb);
    logic [2:0] op;
    logic       rdy;
    @(negedge clk);
    rst_n = r_n; ena = e; mem_rdy = mr; zero = z; opcode_a = opa; opcode_b = opb;
    #1;
    cur_a = out_a;
    cur_b = out_b;
    for (int d = 0; d < 2; d++) begin
      op  = (d == 0) ? opa : opb;
      rdy = (d == 0) ? mr : 1'b1;
      if (!r_n) begin
        m_mode[d] = M_IDLE; m_step[d] = 0; m_skip[d] = 1'b0;
      end
      chk((d == 0) ? "outputs_rdy1" : "outputs_rdy0",
          {22'd0, (d == 0) ? cur_a : cur_b}, {22'd0, model_out(d, rdy, op)});
      if (r_n) model_step(d, rdy, e, z, op);
    end
  endtask

  task automatic start_test(input logic [2:0] op);
    tick(1'b0, 1'b0, 1'b1, 1'b0, op, op);
    tick(1'b1, 1'b1, 1'b1, 1'b0, op, op);
  endtask

  initial begin
    logic [15:0] tr, tr2, tr3;
    logic [2:0]  opa, opb;
    logic        r_n;
    int          hcnt, halt_run;

    for (int d = 0; d < 2; d++) begin m_mode[d] = M_IDLE; m_step[d] = 0; m_skip[d] = 1'b0; end

    // LDA, zero wait: rd in fetches, operand and next fetch; alu_en then load_acc.
    tick(1'b0, 1'b0, 1'b1, 1'b0, O_LDA, O_LDA);
    chk("reset_outputs", {22'd0, cur_a}, 32'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, O_LDA, O_LDA);
    tr = 16'd0; tr2 = 16'd0; tr3 = 16'd0;
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, O_LDA, O_LDA);
      tr[i] = cur_a[I_RD]; tr2[i] = cur_a[I_ALU]; tr3[i] = cur_a[I_LACC];
    end
    chk("lda_rd_trace", {16'd0, tr}, 32'h004B);
    chk("lda_alu_en_trace", {16'd0, tr2}, 32'h0010);
    chk("lda_load_acc_trace", {16'd0, tr3}, 32'h0020);

    // SKZ taken (zero=1 only at decode) then not taken (zero=0 only at decode).
    start_test(O_SKZ);
    tr = 16'd0; tr2 = 16'd0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b1, (i == 2), O_SKZ, O_SKZ);
      tr[i] = cur_a[I_INC];
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b1, (i != 2), O_SKZ, O_SKZ);
      tr2[i] = cur_a[I_INC];
    end
    chk("skz_taken_inc", {16'd0, tr}, 32'h001B);
    chk("skz_not_taken_inc", {16'd0, tr2}, 32'h0003);

    // STO with three not-ready cycles in writeback, then ena low.
    start_test(O_STO);
    tr = 16'd0; tr2 = 16'd0; tr3 = 16'd0;
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, (i < 8), !(i >= 5 && i <= 7), 1'b0, O_STO, O_STO);
      tr[i] = cur_a[I_WR]; tr2[i] = cur_a[I_DOE]; tr3[i] = cur_a[I_RD];
    end
    chk("sto_wr_trace", {16'd0, tr}, 32'h01E0);
    chk("sto_data_oe_trace", {16'd0, tr2}, 32'h01E0);
    chk("sto_rd_trace", {16'd0, tr3}, 32'h0003);
    tick(1'b1, 1'b0, 1'b1, 1'b0, O_STO, O_STO);
    chk("sto_then_idle", {22'd0, cur_a}, 32'd0);

    // JMP, then HLT held through ena toggling, then reset.
    start_test(O_JMP);
    tr = 16'd0; tr2 = 16'd0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, O_JMP, O_JMP);
      tr[i] = cur_a[I_LPC]; tr2[i] = cur_a[I_INC];
    end
    chk("jmp_load_pc", {16'd0, tr}, 32'h0008);
    chk("jmp_inc_pc", {16'd0, tr2}, 32'h0003);
    start_test(O_HLT);
    hcnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0, O_HLT, O_HLT);
      if (cur_a == 10'b00_0000_0001) hcnt++;
    end
    chk("halt_cycles", hcnt, 32'd22);
    tick(1'b0, 1'b1, 1'b1, 1'b0, O_ADD, O_ADD);
    chk("halt_cleared_by_reset", {22'd0, cur_a}, 32'd0);

    // Fetch stall: two not-ready cycles in FETCH1.
    start_test(O_ADD);
    tr = 16'd0; tr2 = 16'd0; tr3 = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, (i == 2), 1'b0, O_ADD, O_ADD);
      tr[i] = cur_a[I_RD] & cur_a[I_LIR]; tr2[i] = cur_a[I_INC]; tr3[i] = cur_b[I_INC];
    end
    chk("stall_rd_load_ir", {16'd0, tr}, 32'h0007);
    chk("stall_inc_pc", {16'd0, tr2}, 32'h0004);
    chk("no_rdy_inc_pc", {16'd0, tr3}, 32'h0003);

    // ena dropped in EXEC: writeback completes, then idle.
    start_test(O_LDA);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, (i < 4), 1'b1, 1'b0, O_LDA, O_LDA);
      if (i == 5) chk("ena_drop_load_acc", {31'd0, cur_a[I_LACC]}, 32'd1);
    end
    chk("ena_drop_idle", {22'd0, cur_a}, 32'd0);

    // Reset asserted while stalled in FETCH2.
    start_test(O_LDA);
    tick(1'b1, 1'b1, 1'b1, 1'b0, O_LDA, O_LDA);
    tick(1'b1, 1'b1, 1'b0, 1'b0, O_LDA, O_LDA);
    chk("fetch2_rd", {31'd0, cur_a[I_RD]}, 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, O_LDA, O_LDA);
    chk("reset_mid_fetch2", {22'd0, cur_a}, 32'd0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, O_LDA, O_LDA);
    chk("idle_after_reset", {22'd0, cur_a}, 32'd0);

    // Randomized run; opcodes only change where the sequencer is not using them.
    opa = O_ADD; opb = O_ADD; halt_run = 0;
    for (int n = 0; n < 4000; n++) begin
      if (m_mode[0] != M_RUN || m_step[0] == 0) begin
        opa = 3'($urandom_range(7));
        if (opa == O_HLT && $urandom_range(3) != 0) opa = O_LDA;
      end
      if (m_mode[1] != M_RUN || m_step[1] == 0) begin
        opb = 3'($urandom_range(7));
        if (opb == O_HLT && $urandom_range(3) != 0) opb = O_STO;
      end
      if (m_mode[0] == M_HALT || m_mode[1] == M_HALT) halt_run++;
      r_n = 1'b1;
      if (halt_run > 6 || $urandom_range(149) == 0) begin
        r_n = 1'b0;
        halt_run = 0;
      end
      tick(r_n, ($urandom_range(7) != 0), ($urandom_range(3) != 0),
           1'($urandom_range(1)), opa, opb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
